// File: rtl/mips_data_arbiter_if.sv
// Bus bundle between the CPU data port, the DMA/loader port and data memory.
// The arbiter connects through the slave modport; the environment uses master.
interface mips_data_arbiter_if;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;

    logic [31:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    modport slave (
        input  data_address, data_write, data_read, data_writedata,
        output data_readdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_address, mem_write, mem_read, mem_writedata,
        input  mem_readdata
    );

    modport master (
        output data_address, data_write, data_read, data_writedata,
        input  data_readdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_address, mem_write, mem_read, mem_writedata,
        output mem_readdata
    );
endinterface

// File: rtl/mips_data_arbiter.sv
// Shares the data-memory port between the MIPS CPU and a DMA/loader.
// CPU has priority; the DMA is forced through after STARVE_MAX lost cycles.
module mips_data_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_enable_i,
    input  logic        cpu_active_i,
    output logic        cpu_clk_enable_o,
    output logic [31:0] stall_count_o,
    mips_data_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_q, starve_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic cpu_req;
    logic xfer_en;
    logic dma_gnt;
    logic cpu_gnt;

    always_comb begin
        cpu_req = cpu_active_i & (bus.data_read | bus.data_write);
        xfer_en = clk_enable_i & ~reset_i;
        // Once the DMA has lost STARVE_MAX cycles in a row it wins the next contention.
        dma_gnt = xfer_en & bus.dma_req & (~cpu_req | (starve_q == STARVE_LIM));
        cpu_gnt = xfer_en & cpu_req & ~dma_gnt;
    end

    always_comb begin
        bus.mem_address   = 32'd0;
        bus.mem_writedata = 32'd0;
        bus.mem_write     = 1'b0;
        bus.mem_read      = 1'b0;
        if (dma_gnt) begin
            bus.mem_address   = bus.dma_addr;
            bus.mem_writedata = bus.dma_wdata;
            bus.mem_write     = bus.dma_we;
            bus.mem_read      = ~bus.dma_we;
        end else if (cpu_gnt) begin
            bus.mem_address   = bus.data_address;
            bus.mem_writedata = bus.data_writedata;
            bus.mem_write     = bus.data_write;
            bus.mem_read      = bus.data_read & ~bus.data_write;
        end
    end

    always_comb begin
        bus.data_readdata = bus.mem_readdata;
        bus.dma_gnt       = dma_gnt;
        bus.dma_rdata     = rdata_q;
        bus.dma_rvalid    = rvalid_q;
        cpu_clk_enable_o  = xfer_en & ~(cpu_req & dma_gnt);
        stall_count_o     = stall_q;
    end

    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (clk_enable_i) begin
            if (dma_gnt || !bus.dma_req) begin
                starve_d = 4'd0;
            end else if (starve_q < STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end
            if (cpu_req && dma_gnt) begin
                stall_d = stall_q + 32'd1;
            end
            if (dma_gnt && !bus.dma_we) begin
                rdata_d  = bus.mem_readdata;
                rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q <= 4'd0;
            stall_q  <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_mips_data_arbiter.sv
// Bench for mips_data_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model with its own memory copy.
module tb_mips_data_arbiter;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        cpu_active;
    logic        cpu_clk_enable;
    logic [31:0] stall_count;

    mips_data_arbiter_if bus ();

    mips_data_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .clk_enable_i     (clk_enable),
        .cpu_active_i     (cpu_active),
        .cpu_clk_enable_o (cpu_clk_enable),
        .stall_count_o    (stall_count),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for data_memory: combinational read, write on the rising edge.
    logic [31:0] mem_arr [256] = '{default: 32'd0};
    assign bus.mem_readdata = mem_arr[bus.mem_address[7:0]];
    always @(posedge clk) begin
        if (bus.mem_write) mem_arr[bus.mem_address[7:0]] <= bus.mem_writedata;
    end

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int          m_lost = 0;
    logic [31:0] m_stalls = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_rvalid = 1'b0;
    logic [31:0] shadow [256] = '{default: 32'd0};

    // Expectations for the cycle currently being evaluated.
    logic        e_creq, e_dwin, e_cwin, e_wr, e_rd, e_reset, e_en, e_dreq;
    logic [31:0] e_addr, e_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic eval(input string tag);
        #2;
        e_reset = reset;
        e_en    = clk_enable;
        e_dreq  = bus.dma_req;
        e_creq  = cpu_active && (bus.data_read || bus.data_write);
        e_dwin  = clk_enable && !reset && bus.dma_req && (!e_creq || m_lost >= STARVE_MAX);
        e_cwin  = clk_enable && !reset && e_creq && !e_dwin;
        e_addr = 32'd0; e_wdata = 32'd0; e_wr = 1'b0; e_rd = 1'b0;
        if (e_dwin) begin
            e_addr = bus.dma_addr; e_wdata = bus.dma_wdata;
            e_wr = bus.dma_we;     e_rd = !bus.dma_we;
        end else if (e_cwin) begin
            e_addr = bus.data_address; e_wdata = bus.data_writedata;
            e_wr = bus.data_write;     e_rd = bus.data_read && !bus.data_write;
        end
        chk({tag, "/gnt"},   32'(bus.dma_gnt),       32'(e_dwin));
        chk({tag, "/cpuce"}, 32'(cpu_clk_enable),    32'(clk_enable && !reset && !(e_creq && e_dwin)));
        chk({tag, "/mwr"},   32'(bus.mem_write),     32'(e_wr));
        chk({tag, "/mrd"},   32'(bus.mem_read),      32'(e_rd));
        chk({tag, "/maddr"}, bus.mem_address,        e_addr);
        if (e_wr) chk({tag, "/mwdata"}, bus.mem_writedata, e_wdata);
        chk({tag, "/crdata"}, bus.data_readdata,     shadow[e_addr[7:0]]);
        chk({tag, "/rvalid"}, 32'(bus.dma_rvalid),   32'(m_rvalid));
        chk({tag, "/rdata"},  bus.dma_rdata,         m_rdata);
        chk({tag, "/stalls"}, stall_count,           m_stalls);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (e_reset) begin
            m_lost = 0; m_stalls = 32'd0; m_rdata = 32'd0; m_rvalid = 1'b0;
        end else if (e_en) begin
            m_rvalid = e_dwin && e_rd;
            if (m_rvalid) m_rdata = shadow[e_addr[7:0]];
            if (e_wr) shadow[e_addr[7:0]] = e_wdata;
            if (e_creq && e_dwin) m_stalls = m_stalls + 32'd1;
            if (e_dwin || !e_dreq) m_lost = 0;
            else if (m_lost < STARVE_MAX) m_lost++;
        end else begin
            m_rvalid = 1'b0;
        end
    endtask

    task automatic set_cpu(input logic act, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_active = act; bus.data_read = rd; bus.data_write = wr;
        bus.data_address = addr; bus.data_writedata = wdata;
    endtask

    task automatic set_dma(input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    endtask

    initial begin
        logic pend_dma, hold_cpu;
        reset = 1'b1;
        clk_enable = 1'b1;
        set_cpu(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        eval("reset0"); tick();
        eval("reset1"); tick();
        reset = 1'b0;

        // 1: DMA only
        set_dma(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        eval("t1w");
        chk("t1w_gnt_const", 32'(bus.dma_gnt), 32'd1);
        chk("t1w_ce_const", 32'(cpu_clk_enable), 32'd1);
        tick();
        set_dma(1'b1, 1'b0, 32'h10, 32'd0);
        eval("t1r");
        chk("t1r_gnt_const", 32'(bus.dma_gnt), 32'd1);
        tick();
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        chk("t1_rvalid_const", 32'(bus.dma_rvalid), 32'd1);
        chk("t1_rdata_const", bus.dma_rdata, 32'hDEADBEEF);
        chk("t1_stall_const", stall_count, 32'd0);
        eval("t1idle"); tick();

        // 2: CPU only
        set_cpu(1'b1, 1'b0, 1'b1, 32'h20, 32'h20);
        eval("t2sw");
        chk("t2sw_mwr_const", 32'(bus.mem_write), 32'd1);
        chk("t2sw_addr_const", bus.mem_address, 32'h20);
        tick();
        set_cpu(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        eval("t2lw");
        chk("t2lw_rdata_const", bus.data_readdata, 32'h20);
        chk("t2lw_ce_const", 32'(cpu_clk_enable), 32'd1);
        tick();

        // 3: continuous contention
        set_dma(1'b1, 1'b0, 32'h10, 32'd0);
        for (int i = 1; i <= 12; i++) begin
            eval("t3");
            chk("t3_gnt_const", 32'(bus.dma_gnt), 32'((i == 5) || (i == 10)));
            chk("t3_ce_const", 32'(cpu_clk_enable), 32'(!((i == 5) || (i == 10))));
            tick();
        end
        chk("t3_stalls_const", stall_count, 32'd2);

        // 4: both strobes
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        set_cpu(1'b1, 1'b1, 1'b1, 32'h30, 32'h55);
        eval("t4");
        chk("t4_mwr_const", 32'(bus.mem_write), 32'd1);
        chk("t4_mrd_const", 32'(bus.mem_read), 32'd0);
        tick();

        // 5: clk_enable low during contention with three lost cycles banked
        set_cpu(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        set_dma(1'b1, 1'b0, 32'h10, 32'd0);
        for (int i = 0; i < 3; i++) begin eval("t5pre"); tick(); end
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            eval("t5off");
            chk("t5off_gnt_const", 32'(bus.dma_gnt), 32'd0);
            chk("t5off_strobes_const", 32'({bus.mem_write, bus.mem_read}), 32'd0);
            tick();
        end
        clk_enable = 1'b1;
        eval("t5on1");
        chk("t5on1_gnt_const", 32'(bus.dma_gnt), 32'd0);
        tick();
        eval("t5on2");
        chk("t5on2_gnt_const", 32'(bus.dma_gnt), 32'd1);
        tick();
        chk("t5_stalls_const", stall_count, 32'd3);

        // 7: request withdrawn just before it would be forced
        for (int i = 0; i < 3; i++) begin eval("t7pre"); tick(); end
        bus.dma_req = 1'b0;
        eval("t7drop");
        chk("t7drop_gnt_const", 32'(bus.dma_gnt), 32'd0);
        tick();
        bus.dma_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            eval("t7again");
            chk("t7again_gnt_const", 32'(bus.dma_gnt), 32'(i == 5));
            tick();
        end

        // 6: reset in the cycle after a DMA read grant
        set_cpu(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_dma(1'b1, 1'b0, 32'h30, 32'd0);
        eval("t6rd"); tick();
        set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        eval("t6rst"); tick();
        chk("t6_rvalid_const", 32'(bus.dma_rvalid), 32'd0);
        chk("t6_rdata_const", bus.dma_rdata, 32'd0);
        chk("t6_stalls_const", stall_count, 32'd0);
        reset = 1'b0;
        set_cpu(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        set_dma(1'b1, 1'b1, 32'h40, 32'h1234);
        for (int i = 1; i <= 5; i++) begin
            eval("t6starve");
            chk("t6starve_gnt_const", 32'(bus.dma_gnt), 32'(i == 5));
            tick();
        end

        // Random traffic; requesters hold their request while not served.
        pend_dma = 1'b0;
        hold_cpu = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_dma)
                set_dma($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        {24'd0, 8'($urandom)}, $urandom);
            if (!hold_cpu)
                set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), {24'd0, 8'($urandom)}, $urandom);
            clk_enable = $urandom_range(0, 9) != 0;
            reset = $urandom_range(0, 49) == 0;
            eval("rand");
            pend_dma = e_dreq && !e_dwin && !e_reset;
            hold_cpu = e_creq && !e_cwin && !e_reset;
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
